// File: rtl/puf_eval_ctrl.sv
// Sequencing controller for the parallel PUF array: repeats one challenge REPS times,
// majority-votes each response bit and flags bits whose votes were not unanimous.
module puf_eval_ctrl #(
    parameter int N           = 128,
    parameter int REPS        = 5,
    parameter int EVAL_CYCLES = 32,
    parameter int GAP_CYCLES  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [N-1:0] req_challenge,
    input  logic         abort,
    output logic         puf_start,
    output logic [N-1:0] puf_challenge,
    input  logic [N-1:0] puf_response,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic [N-1:0] rsp_unstable,
    output logic         busy
);

    localparam int VW      = $clog2(REPS + 1);
    localparam int RW      = $clog2(REPS + 1);
    localparam int CNT_MAX = (EVAL_CYCLES > GAP_CYCLES) ? EVAL_CYCLES : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [VW-1:0] HALF      = VW'(REPS / 2);
    localparam logic [VW-1:0] ALL_VOTES = VW'(REPS);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPS);
    localparam logic [CW-1:0] EVAL_LOAD = CW'(EVAL_CYCLES);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT,
        GAP,
        DONE
    } state_t;

    state_t              stateQ, stateD;
    logic                initQ;
    logic [CW-1:0]       cntQ, cntD;
    logic [RW-1:0]       repQ, repD;
    logic [RW-1:0]       repInc;
    logic [N-1:0][VW-1:0] voteQ, voteD;
    logic [N-1:0][VW-1:0] voteSum;
    logic [N-1:0]        chalQ, chalD;
    logic [N-1:0]        dataQ, dataD;
    logic [N-1:0]        unstQ, unstD;
    logic [N-1:0]        dataNext, unstNext;

    // Votes as they will stand once the current response sample is folded in.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            voteSum[i] = voteQ[i] + VW'(puf_response[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            dataNext[i] = (voteSum[i] > HALF);
            unstNext[i] = (voteSum[i] != '0) && (voteSum[i] != ALL_VOTES);
        end
    end

    assign repInc = repQ + RW'(1);

    // Next-state and datapath control; abort outranks both the WAIT sample and DONE entry.
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        repD   = repQ;
        voteD  = voteQ;
        chalD  = chalQ;
        dataD  = dataQ;
        unstD  = unstQ;

        unique case (stateQ)
            IDLE: begin
                if (req_valid && initQ) begin
                    chalD  = req_challenge;
                    voteD  = '0;
                    repD   = '0;
                    cntD   = '0;
                    stateD = START;
                end
            end

            START: begin
                if (abort) begin
                    voteD  = '0;
                    repD   = '0;
                    cntD   = '0;
                    stateD = IDLE;
                end else begin
                    cntD   = EVAL_LOAD;
                    stateD = WAIT;
                end
            end

            WAIT: begin
                if (abort) begin
                    voteD  = '0;
                    repD   = '0;
                    cntD   = '0;
                    stateD = IDLE;
                end else if (cntQ == CNT_ONE) begin
                    voteD = voteSum;
                    repD  = repInc;
                    cntD  = '0;
                    if (repInc == REP_LAST) begin
                        dataD  = dataNext;
                        unstD  = unstNext;
                        stateD = DONE;
                    end else if (GAP_CYCLES == 0) begin
                        stateD = START;
                    end else begin
                        cntD   = GAP_LOAD;
                        stateD = GAP;
                    end
                end else begin
                    cntD = cntQ - CNT_ONE;
                end
            end

            GAP: begin
                if (abort) begin
                    voteD  = '0;
                    repD   = '0;
                    cntD   = '0;
                    stateD = IDLE;
                end else if (cntQ == CNT_ONE) begin
                    cntD   = '0;
                    stateD = START;
                end else begin
                    cntD = cntQ - CNT_ONE;
                end
            end

            DONE: begin
                if (abort || rsp_ready) begin
                    stateD = IDLE;
                end
            end

            default: begin
                voteD  = '0;
                repD   = '0;
                cntD   = '0;
                stateD = IDLE;
            end
        endcase
    end

    // initQ keeps req_ready low until the first clock edge seen with rst_n released.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ <= IDLE;
            initQ  <= 1'b0;
            cntQ   <= '0;
            repQ   <= '0;
            voteQ  <= '0;
            chalQ  <= '0;
            dataQ  <= '0;
            unstQ  <= '0;
        end else begin
            stateQ <= stateD;
            initQ  <= 1'b1;
            cntQ   <= cntD;
            repQ   <= repD;
            voteQ  <= voteD;
            chalQ  <= chalD;
            dataQ  <= dataD;
            unstQ  <= unstD;
        end
    end

    assign req_ready     = (stateQ == IDLE) && initQ;
    assign busy          = (stateQ != IDLE);
    assign puf_start     = (stateQ == START);
    assign rsp_valid     = (stateQ == DONE);
    assign puf_challenge = chalQ;
    assign rsp_data      = dataQ;
    assign rsp_unstable  = unstQ;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: a PUF model replays per-evaluation response
// vectors and a majority-count model predicts the voted result and instability mask.
module tb_puf_eval_ctrl;

    localparam int N    = 128;
    localparam int REPS = 3;
    localparam int EVAL = 4;
    localparam int GAP  = 2;
    localparam int PERIOD_REL = 1 + EVAL + GAP;
    localparam int RSP_REL    = REPS * (1 + EVAL) + (REPS - 1) * GAP + 1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [N-1:0] req_challenge = '0;
    logic         abort = 1'b0;
    logic         puf_start;
    logic [N-1:0] puf_challenge;
    logic [N-1:0] puf_response = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [N-1:0] rsp_data;
    logic [N-1:0] rsp_unstable;
    logic         busy;

    int checks = 0;
    int fails  = 0;
    int cyc = 0;
    int acceptCyc = 0;
    int startCount = 0;
    int startRel[$];
    logic [N-1:0] pat [REPS];
    logic [N-1:0] lastChalExp = '0;

    puf_eval_ctrl #(
        .N(N), .REPS(REPS), .EVAL_CYCLES(EVAL), .GAP_CYCLES(GAP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_challenge(req_challenge),
        .abort(abort),
        .puf_start(puf_start), .puf_challenge(puf_challenge), .puf_response(puf_response),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_unstable(rsp_unstable),
        .busy(busy)
    );

    // Clock and a cycle index that reads as the current cycle number at every negedge.
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // PUF array model: each start pulse selects the next evaluation's response vector.
    always @(negedge clk) begin
        if (puf_start === 1'b1) begin
            startRel.push_back(cyc - acceptCyc);
            if (startCount < REPS) puf_response = pat[startCount];
            else puf_response = '0;
            startCount++;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [N-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference: count ones per bit over all evaluations, majority and unanimity.
    task automatic modelVote(output logic [N-1:0] d, output logic [N-1:0] u);
        int ones;
        for (int b = 0; b < N; b++) begin
            ones = 0;
            for (int k = 0; k < REPS; k++) ones += int'(pat[k][b]);
            d[b] = (2 * ones > REPS);
            u[b] = (ones != 0) && (ones != REPS);
        end
    endtask

    task automatic submit(input logic [N-1:0] chal, output bit ok);
        ok = 1'b0;
        req_challenge = chal;
        req_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (req_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        acceptCyc = cyc;
        startCount = 0;
        startRel.delete();
        if (ok) lastChalExp = chal;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic waitRsp(output int rel, output bit ok);
        ok = 1'b0;
        rel = -1;
        for (int i = 0; i < 300; i++) begin
            if (rsp_valid === 1'b1) begin
                ok = 1'b1;
                rel = cyc - acceptCyc;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (puf_start !== 1'b0) begin fails++; $display("[TB] FAIL reset_puf_start: got %b want 0", puf_start); end
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (puf_challenge !== '0) begin fails++; $display("[TB] FAIL reset_puf_challenge: got %h want 0", puf_challenge); end
        checks++; if (rsp_data !== '0) begin fails++; $display("[TB] FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (rsp_unstable !== '0) begin fails++; $display("[TB] FAIL reset_rsp_unstable: got %h want 0", rsp_unstable); end
        rst_n = 1'b1;
        lastChalExp = '0;
        checks++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL release_req_ready_early: got %b want 0", req_ready); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL release_req_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_constant;
        logic [N-1:0] r, chal, d, u;
        int rel;
        bit ok, startsOk;
        r = rand128();
        for (int k = 0; k < REPS; k++) pat[k] = r;
        chal = {16{8'hA5}};
        modelVote(d, u);
        submit(chal, ok);
        checks++; if (!ok) begin fails++; $display("[TB] FAIL const_accept: req_ready never seen"); end
        waitRsp(rel, ok);
        checks++; if (!ok || rel != RSP_REL) begin fails++; $display("[TB] FAIL const_rsp_cycle: got %0d want %0d", rel, RSP_REL); end
        checks++; if (rsp_data !== r || rsp_data !== d) begin fails++; $display("[TB] FAIL const_rsp_data: got %h want %h", rsp_data, r); end
        checks++; if (rsp_unstable !== '0) begin fails++; $display("[TB] FAIL const_rsp_unstable: got %h want 0", rsp_unstable); end
        checks++; if (puf_challenge !== chal) begin fails++; $display("[TB] FAIL const_puf_challenge: got %h want %h", puf_challenge, chal); end
        startsOk = (startRel.size() == REPS);
        for (int k = 0; k < REPS && startsOk; k++) startsOk = (startRel[k] == 1 + k * PERIOD_REL);
        checks++; if (!startsOk) begin fails++; $display("[TB] FAIL const_start_cycles: got %p want 1,%0d,%0d", startRel, 1 + PERIOD_REL, 1 + 2 * PERIOD_REL); end
        checks++; if (busy !== 1'b1) begin fails++; $display("[TB] FAIL const_busy_hs: got %b want 1", busy); end
        @(negedge clk);
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL const_idle_after: req_ready %b busy %b want 1 0", req_ready, busy); end
    endtask

    task automatic test_vote;
        logic [N-1:0] d, u;
        int rel;
        bit ok;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < REPS; k++) pat[k] = rand128();
            if (j == 0) begin
                pat[0][0] = 1'b1; pat[1][0] = 1'b0; pat[2][0] = 1'b1;
                pat[0][1] = 1'b0; pat[1][1] = 1'b0; pat[2][1] = 1'b1;
            end
            modelVote(d, u);
            submit(rand128(), ok);
            waitRsp(rel, ok);
            checks++; if (!ok) begin fails++; $display("[TB] FAIL vote_rsp_timeout: job %0d", j); end
            checks++; if (rsp_data !== d) begin fails++; $display("[TB] FAIL vote_data job %0d: got %h want %h", j, rsp_data, d); end
            checks++; if (rsp_unstable !== u) begin fails++; $display("[TB] FAIL vote_unstable job %0d: got %h want %h", j, rsp_unstable, u); end
            if (j == 0) begin
                checks++; if (rsp_data[1:0] !== 2'b01) begin fails++; $display("[TB] FAIL vote_bits10_data: got %b want 01", rsp_data[1:0]); end
                checks++; if (rsp_unstable[1:0] !== 2'b11) begin fails++; $display("[TB] FAIL vote_bits10_unstable: got %b want 11", rsp_unstable[1:0]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold;
        logic [N-1:0] d, u;
        int rel;
        bit ok;
        for (int k = 0; k < REPS; k++) pat[k] = rand128();
        modelVote(d, u);
        rsp_ready = 1'b0;
        submit(rand128(), ok);
        waitRsp(rel, ok);
        checks++; if (!ok) begin fails++; $display("[TB] FAIL hold_rsp_timeout"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_unstable !== u || req_ready !== 1'b0) begin
                fails++;
                $display("[TB] FAIL hold_cycle %0d: valid %b ready %b data %h unst %h want 1 0 %h %h",
                         i, rsp_valid, req_ready, rsp_data, rsp_unstable, d, u);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL hold_release_req_ready: got %b want 1", req_ready); end
        for (int k = 0; k < REPS; k++) pat[k] = rand128();
        modelVote(d, u);
        submit(rand128(), ok);
        waitRsp(rel, ok);
        checks++; if (!ok || rsp_data !== d || rsp_unstable !== u) begin fails++; $display("[TB] FAIL hold_second_job: data %h unst %h want %h %h", rsp_data, rsp_unstable, d, u); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_gap;
        int target;
        bit ok, seen;
        for (int k = 0; k < REPS; k++) pat[k] = rand128();
        submit(rand128(), ok);
        target = 1 + EVAL + 1;
        for (int i = 0; i < 100 && (cyc - acceptCyc) < target; i++) @(negedge clk);
        checks++; if (busy !== 1'b1 || puf_start !== 1'b0) begin fails++; $display("[TB] FAIL gap_state: busy %b start %b want 1 0", busy, puf_start); end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || busy !== 1'b0 || puf_start !== 1'b0 || rsp_valid !== 1'b0 ||
            puf_challenge !== '0 || rsp_data !== '0 || rsp_unstable !== '0) begin
            fails++;
            $display("[TB] FAIL midgap_reset_values: ready %b busy %b start %b valid %b chal %h data %h unst %h",
                     req_ready, busy, puf_start, rsp_valid, puf_challenge, rsp_data, rsp_unstable);
        end
        rst_n = 1'b1;
        lastChalExp = '0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL midgap_release_ready: got %b want 1", req_ready); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (seen) begin fails++; $display("[TB] FAIL midgap_lost_job: rsp_valid got 1 want 0"); end
    endtask

    task automatic test_abort;
        logic [N-1:0] d, u;
        int target, rel;
        bit ok, seen;
        for (int k = 0; k < REPS; k++) pat[k] = '1;
        submit(rand128(), ok);
        target = 1 + PERIOD_REL + EVAL;
        for (int i = 0; i < 100 && (cyc - acceptCyc) < target; i++) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checks++; if (busy !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL abort_idle: busy %b ready %b valid %b want 0 1 0", busy, req_ready, rsp_valid); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++; if (startRel.size() != 2) begin fails++; $display("[TB] FAIL abort_starts: got %0d want 2", startRel.size()); end
        checks++; if (seen) begin fails++; $display("[TB] FAIL abort_rsp_valid: got 1 want 0"); end
        pat[0] = '1; pat[1] = '0; pat[2] = '0;
        modelVote(d, u);
        submit(rand128(), ok);
        waitRsp(rel, ok);
        checks++; if (!ok || rsp_data !== d || rsp_unstable !== u) begin fails++; $display("[TB] FAIL abort_next_votes: data %h unst %h want %h %h", rsp_data, rsp_unstable, d, u); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        localparam int J = 4;
        logic [N-1:0] d, u, nextChal;
        logic [N-1:0] expD[$], expU[$];
        int accepts, got;
        bit acc, hs;
        accepts = 0;
        got = 0;
        nextChal = rand128();
        req_challenge = nextChal;
        req_valid = 1'b1;
        for (int c = 0; c < 2000 && got < J; c++) begin
            acc = (req_valid === 1'b1 && req_ready === 1'b1);
            hs  = (rsp_valid === 1'b1 && rsp_ready === 1'b1);
            if (acc) begin
                checks++; if (accepts != got || hs) begin fails++; $display("[TB] FAIL b2b_accept_once: accepts %0d responses %0d hs %b", accepts, got, hs); end
                for (int k = 0; k < REPS; k++) pat[k] = rand128() ^ nextChal;
                modelVote(d, u);
                expD.push_back(d);
                expU.push_back(u);
                acceptCyc = cyc;
                startCount = 0;
                startRel.delete();
            end
            if (hs) begin
                checks++;
                if (expD.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL b2b_unexpected_rsp: data %h", rsp_data);
                end else begin
                    if (rsp_data !== expD[0] || rsp_unstable !== expU[0]) begin
                        fails++;
                        $display("[TB] FAIL b2b_rsp %0d: data %h unst %h want %h %h", got, rsp_data, rsp_unstable, expD[0], expU[0]);
                    end
                    void'(expD.pop_front());
                    void'(expU.pop_front());
                end
                got++;
            end
            @(negedge clk);
            if (acc) begin
                lastChalExp = nextChal;
                accepts++;
                nextChal = nextChal + 1'b1;
                req_challenge = nextChal;
                if (accepts == J) req_valid = 1'b0;
            end
            checks++; if (puf_challenge !== lastChalExp) begin fails++; $display("[TB] FAIL b2b_challenge: got %h want %h", puf_challenge, lastChalExp); end
        end
        req_valid = 1'b0;
        checks++; if (got != J || accepts != J) begin fails++; $display("[TB] FAIL b2b_counts: responses %0d accepts %0d want %0d", got, accepts, J); end
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < REPS; k++) pat[k] = '0;
        @(negedge clk);
        test_reset();
        test_constant();
        test_vote();
        test_hold();
        test_reset_mid_gap();
        test_abort();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
